// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: {cout,sum} = a + b + cin, one bit per clock, LSB first.
// The per-bit cell is two half adders plus an OR; the carry flop closes the loop.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for start; result registers hold the last answer
//   S_SHIFT | one full-adder step per edge, WIDTH steps in total
//   S_DONE  | one-cycle done pulse; sum/cout were updated on entry

module half_add (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic s1, c1, s_bit, c2, carry_next;

    half_add u_ha0 (.a_i(sa_q[0]), .b_i(sb_q[0]), .s_o(s1),    .c_o(c1));
    half_add u_ha1 (.a_i(s1),      .b_i(carry_q), .s_o(s_bit), .c_o(c2));
    assign carry_next = c1 | c2;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH steps.
                acc_d   = {s_bit, acc_q[WIDTH-1:1]};
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                carry_d = carry_next;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    sum_d   = {s_bit, acc_q[WIDTH-1:1]};
                    cout_d  = carry_next;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus a held-start random stream
// checked against plain-arithmetic expected sums and the fixed WIDTH+2 cycle cadence.

module tb_serial_adder;
    localparam int W = 8;
    localparam int PERIOD = W + 2;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int n_total = 0;
    int n_bad   = 0;

    logic [W:0] last_res;

    serial_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // One addition: load edge, WIDTH shift edges, done cycle, back to idle.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                          input bit poke);
        logic [W:0] exp;
        exp   = ref_add(xa, xb, xc);
        a     = xa;
        b     = xb;
        cin   = xc;
        start = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < W; i++) begin
            check_eq("busy_run", busy, 1'b1);
            check_eq("done_early", done, 1'b0);
            check_eq("hold_run", {cout, sum}, last_res);
            a     = W'($urandom);
            b     = W'($urandom);
            cin   = 1'($urandom);
            start = 1'b0;
            if (poke && i == 3) begin
                start = 1'b1;
                a     = 8'h7F;
                b     = 8'h7F;
            end
            @(posedge clk); #1;
        end
        check_eq("done_pulse", done, 1'b1);
        check_eq("busy_done", busy, 1'b0);
        check_eq("result", {cout, sum}, exp);
        last_res = exp;
        start = 1'b0;
        @(posedge clk); #1;
        check_eq("done_once", done, 1'b0);
        check_eq("busy_after", busy, 1'b0);
        check_eq("hold_after", {cout, sum}, last_res);
    endtask

    initial begin
        logic [W:0] pending;
        logic [W:0] shown;
        int ph;

        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        last_res = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_outs", {busy, done, cout, sum}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check_eq("idle_outs", {busy, done, cout, sum}, '0);
        end

        run_op(8'h03, 8'h05, 1'b0, 0);
        check_eq("basic_sum", sum, 8'h08);
        run_op(8'hFF, 8'h01, 1'b0, 0);
        check_eq("wrap_cout", {cout, sum}, 9'h100);
        run_op(8'hFF, 8'hFF, 1'b1, 0);
        check_eq("max_sum", {cout, sum}, 9'h1FF);
        run_op(8'h10, 8'h20, 1'b0, 1);
        check_eq("ignore_start", {cout, sum}, 9'h030);

        // Reset in the middle of a computation.
        a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_outs", {busy, done, cout, sum}, '0);
        last_res = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check_eq("rst_mid_quiet", {busy, done, cout, sum}, '0);
        end
        run_op(8'h01, 8'h01, 1'b0, 0);
        check_eq("post_rst_sum", sum, 8'h02);

        for (int i = 0; i < 5; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), 0);

        // Held start: a load every PERIOD edges, the first on the very next edge.
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        start   = 1'b1;
        pending = '0;
        shown   = last_res;
        for (int c = 0; c < 200 * PERIOD; c++) begin
            ph = c % PERIOD;
            @(posedge clk);
            if (ph == 0) pending = ref_add(a, b, cin);
            #1;
            if (ph == W) shown = pending;
            check_eq("b2b_busy", busy, ph < W);
            check_eq("b2b_done", done, ph == W);
            check_eq("b2b_result", {cout, sum}, shown);
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
        end
        start = 1'b0;
        repeat (PERIOD) @(posedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
